udp_tx_sched: RTL

UDP_TX_SCHED -- requirements
Module: udp_tx_sched

---
 rtl/udp_tx_sched.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/udp_tx_sched.sv
// udp_tx_sched: round-robin scheduler that merges three frame sources
// (0=ARP/ICMP, 1=UDP1, 2=UDP2) onto one registered MAC transmit bus.
// A grant is held for a whole frame (SOP..EOP), followed by a 1-cycle gap.
// Optional idle-bus watchdog: define UDP_TX_SCHED_WDOG_EN to compile it in.
module udp_tx_sched #(
    parameter int unsigned TIMEOUT = 2047
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_rdy,
    input  logic        req0,
    input  logic        req1,
    input  logic        req2,
    input  logic [1:0]  tx_mod0,
    input  logic        tx_wren0,
    input  logic        tx_sop0,
    input  logic        tx_eop0,
    input  logic [31:0] tx_data0,
    input  logic [1:0]  tx_mod1,
    input  logic        tx_wren1,
    input  logic        tx_sop1,
    input  logic        tx_eop1,
    input  logic [31:0] tx_data1,
    input  logic [1:0]  tx_mod2,
    input  logic        tx_wren2,
    input  logic        tx_sop2,
    input  logic        tx_eop2,
    input  logic [31:0] tx_data2,
    output logic        gnt0,
    output logic        gnt1,
    output logic        gnt2,
    output logic        tx_rdy0,
    output logic        tx_rdy1,
    output logic        tx_rdy2,
    output logic [1:0]  tx_mod,
    output logic        tx_wren,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic [31:0] tx_data,
    output logic        busy,
    output logic        abort
);

    typedef enum logic [1:0] {IDLE, WAIT_SOP, XFER, GAP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_gnt;
    logic [1:0]  r_idx;
    logic [1:0]  r_last;
    logic [1:0]  r_tx_mod;
    logic        r_tx_wren;
    logic        r_tx_sop;
    logic        r_tx_eop;
    logic [31:0] r_tx_data;

    logic [2:0]  w_req;
    logic [2:0]  w_wren;
    logic [2:0]  w_sop;
    logic [2:0]  w_eop;
    logic [1:0]  w_mod  [3];
    logic [31:0] w_data [3];
    logic [1:0]  w_c1;
    logic [1:0]  w_c2;
    logic [1:0]  w_pick;
    logic        w_any;
    logic        w_g_req;
    logic        w_g_wren;
    logic        w_g_sop;
    logic        w_g_eop;
    logic        w_active;
    logic        w_abort;
    logic        w_wdog_hit;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("udp_tx_sched: TIMEOUT must be in 1..65535");
    end

    function automatic logic [1:0] next_src(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign w_req     = {req2, req1, req0};
    assign w_wren    = {tx_wren2, tx_wren1, tx_wren0};
    assign w_sop     = {tx_sop2, tx_sop1, tx_sop0};
    assign w_eop     = {tx_eop2, tx_eop1, tx_eop0};
    assign w_mod[0]  = tx_mod0;
    assign w_mod[1]  = tx_mod1;
    assign w_mod[2]  = tx_mod2;
    assign w_data[0] = tx_data0;
    assign w_data[1] = tx_data1;
    assign w_data[2] = tx_data2;

    // Round robin: first requester after the last completed grant.
    assign w_c1   = next_src(r_last);
    assign w_c2   = next_src(w_c1);
    assign w_any  = |w_req;
    assign w_pick = w_req[w_c1] ? w_c1 : (w_req[w_c2] ? w_c2 : r_last);

    assign w_g_req  = w_req[r_idx];
    assign w_g_wren = w_wren[r_idx];
    assign w_g_sop  = w_sop[r_idx];
    assign w_g_eop  = w_eop[r_idx];
    assign w_active = (r_state == WAIT_SOP) || (r_state == XFER);

    // Next-state decode and watchdog abort request.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) w_state_nxt = WAIT_SOP;
            end
            WAIT_SOP: begin
                if (w_g_wren && w_g_sop) begin
                    w_state_nxt = w_g_eop ? GAP : XFER;
                end else if (!w_g_req) begin
                    w_state_nxt = IDLE;
                end else if (w_wdog_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = GAP;
                end
            end
            XFER: begin
                if (w_g_wren && w_g_eop) begin
                    w_state_nxt = GAP;
                end else if (w_wdog_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = GAP;
                end
            end
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register, grant and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_last  <= 2'd2;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_any) begin
                r_idx <= w_pick;
                r_gnt <= 3'b001 << w_pick;
            end else if (w_active && w_state_nxt == GAP) begin
                r_gnt  <= '0;
                r_last <= r_idx;
            end else if (w_state_nxt == IDLE) begin
                r_gnt <= '0;
            end
        end
    end

    // Output bus: granted source delayed one cycle, zero outside a grant.
    always_ff @(posedge clk) begin
        if (rst || !w_active) begin
            r_tx_mod  <= '0;
            r_tx_wren <= 1'b0;
            r_tx_sop  <= 1'b0;
            r_tx_eop  <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_tx_mod  <= w_mod[r_idx];
            r_tx_wren <= w_g_wren && !w_abort;
            r_tx_sop  <= w_g_sop;
            r_tx_eop  <= w_g_eop;
            r_tx_data <= w_data[r_idx];
        end
    end

`ifdef UDP_TX_SCHED_WDOG_EN
    localparam logic [15:0] LP_WDOG_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_wdog;
    logic        r_abort;

    assign w_wdog_hit = w_active && !w_g_wren && (r_wdog == LP_WDOG_LAST);

    // Count idle-bus cycles inside a grant; any granted word restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_abort;
            if (w_active && !w_g_wren && (w_state_nxt == r_state)) begin
                r_wdog <= r_wdog + 16'd1;
            end else begin
                r_wdog <= '0;
            end
        end
    end

    assign abort = r_abort;
`else
    assign w_wdog_hit = 1'b0;
    assign abort      = 1'b0;
`endif

    assign gnt0    = r_gnt[0];
    assign gnt1    = r_gnt[1];
    assign gnt2    = r_gnt[2];
    assign tx_rdy0 = tx_rdy & r_gnt[0];
    assign tx_rdy1 = tx_rdy & r_gnt[1];
    assign tx_rdy2 = tx_rdy & r_gnt[2];
    assign tx_mod  = r_tx_mod;
    assign tx_wren = r_tx_wren;
    assign tx_sop  = r_tx_sop;
    assign tx_eop  = r_tx_eop;
    assign tx_data = r_tx_data;
    assign busy    = (r_state != IDLE);

endmodule
